// File: rtl/image_sender.sv
// Pixel UART transmitter: buffers 24-bit RGB pixels and writes them MSB-first, one byte
// at a time, to the RS232 UART core over Avalon-MM, polling STATUS.TX_OK before each byte.
module image_sender #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             avm_clk,
  input  logic             avm_rst_n,
  input  logic [23:0]      i_data,
  input  logic             i_valid,
  output logic             o_ready,
  output logic             o_busy,
  output logic             o_done,
  output logic [CNT_W-1:0] o_pixel_cnt,
  output logic [4:0]       avm_address,
  output logic             avm_read,
  output logic             avm_write,
  output logic [31:0]      avm_writedata,
  input  logic [31:0]      avm_readdata,
  input  logic             avm_waitrequest
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  localparam logic [4:0] ADDR_TX     = 5'd4;
  localparam logic [4:0] ADDR_STATUS = 5'd8;
  localparam int         TX_OK_BIT   = 6;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CHECK = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;

  logic [23:0]      mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             push;
  logic             pop;

  logic [1:0]       state;
  logic [23:0]      pix_r;
  logic [1:0]       byte_idx;
  logic             gap;
  logic [7:0]       tx_byte;
  logic             unused_rd;

  assign o_ready   = (count != FULL_CNT);
  assign o_busy    = (state != S_IDLE) || (count != '0);
  assign push      = i_valid & o_ready;
  assign pop       = (state == S_IDLE) && (count != '0);
  assign unused_rd = ^{avm_readdata[31:TX_OK_BIT+1], avm_readdata[TX_OK_BIT-1:0]};

  // NOTE: pixel storage has no reset; the pointers and count alone define what is valid.
  always_ff @(posedge avm_clk) begin
    if (push) mem[wr_ptr] <= i_data;
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge avm_clk or negedge avm_rst_n) begin
    if (!avm_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + (PTR_W + 1)'(1);
        2'b01:   count <= count - (PTR_W + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: default assignment first so no latch is inferred for unlisted byte_idx values.
  always_comb begin
    tx_byte = pix_r[23:16];
    case (byte_idx)
      2'd1:    tx_byte = pix_r[15:8];
      2'd2:    tx_byte = pix_r[7:0];
      default: tx_byte = pix_r[23:16];
    endcase
  end

  // gap marks the mandatory idle cycle between one accepted command and the next.
  always_ff @(posedge avm_clk or negedge avm_rst_n) begin
    if (!avm_rst_n) begin
      state         <= S_IDLE;
      pix_r         <= '0;
      byte_idx      <= '0;
      gap           <= 1'b0;
      avm_read      <= 1'b0;
      avm_write     <= 1'b0;
      avm_address   <= ADDR_STATUS;
      avm_writedata <= '0;
      o_done        <= 1'b0;
      o_pixel_cnt   <= '0;
    end else begin
      o_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (pop) begin
            pix_r       <= mem[rd_ptr];
            byte_idx    <= 2'd0;
            state       <= S_CHECK;
            avm_read    <= 1'b1;
            avm_address <= ADDR_STATUS;
          end
        end
        S_CHECK: begin
          if (gap) begin
            gap         <= 1'b0;
            avm_read    <= 1'b1;
            avm_address <= ADDR_STATUS;
          end else if (avm_read && !avm_waitrequest) begin
            avm_read <= 1'b0;
            gap      <= 1'b1;
            if (avm_readdata[TX_OK_BIT]) state <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (gap) begin
            gap           <= 1'b0;
            avm_write     <= 1'b1;
            avm_address   <= ADDR_TX;
            avm_writedata <= {24'b0, tx_byte};
          end else if (avm_write && !avm_waitrequest) begin
            avm_write <= 1'b0;
            if (byte_idx == 2'd2) begin
              state       <= S_IDLE;
              o_done      <= 1'b1;
              o_pixel_cnt <= o_pixel_cnt + CNT_W'(1);
            end else begin
              byte_idx <= byte_idx + 2'd1;
              state    <= S_CHECK;
              gap      <= 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_image_sender.sv
// Directed bench for image_sender: a scripted UART slave logs every accepted byte and
// STATUS poll; each scenario task compares against hand-computed values.
module tb_image_sender;

  logic        avm_clk = 1'b0;
  logic        avm_rst_n = 1'b0;
  logic [23:0] i_data = '0;
  logic        i_valid = 1'b0;
  logic        o_ready, o_busy, o_done;
  logic [15:0] o_pixel_cnt;
  logic [4:0]  avm_address;
  logic        avm_read, avm_write;
  logic [31:0] avm_writedata;
  logic [31:0] avm_readdata = '0;
  logic        avm_waitrequest = 1'b0;

  // Narrow-counter instance with an always-ready slave, for the wrap scenario.
  logic [23:0] i_data2 = '0;
  logic        i_valid2 = 1'b0;
  logic        o_ready2, o_busy2, o_done2;
  logic [1:0]  o_pixel_cnt2;
  logic [4:0]  avm_address2;
  logic        avm_read2, avm_write2;
  logic [31:0] avm_writedata2;
  logic [31:0] avm_readdata2 = 32'h40;
  logic        avm_waitrequest2 = 1'b0;

  int total = 0;
  int bad   = 0;

  always #5 avm_clk = ~avm_clk;

  image_sender #(.DEPTH(4), .CNT_W(16)) u_dut (
    .avm_clk(avm_clk), .avm_rst_n(avm_rst_n),
    .i_data(i_data), .i_valid(i_valid), .o_ready(o_ready), .o_busy(o_busy),
    .o_done(o_done), .o_pixel_cnt(o_pixel_cnt),
    .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
    .avm_writedata(avm_writedata), .avm_readdata(avm_readdata),
    .avm_waitrequest(avm_waitrequest)
  );

  image_sender #(.DEPTH(4), .CNT_W(2)) u_dut_wrap (
    .avm_clk(avm_clk), .avm_rst_n(avm_rst_n),
    .i_data(i_data2), .i_valid(i_valid2), .o_ready(o_ready2), .o_busy(o_busy2),
    .o_done(o_done2), .o_pixel_cnt(o_pixel_cnt2),
    .avm_address(avm_address2), .avm_read(avm_read2), .avm_write(avm_write2),
    .avm_writedata(avm_writedata2), .avm_readdata(avm_readdata2),
    .avm_waitrequest(avm_waitrequest2)
  );

  // Slave model state and transaction logs.
  int         stall_cfg  = 0;
  int         zero_polls = 0;
  int         stall_seen = 0;
  int         zero_seen  = 0;
  int         reads_since = 0;
  int         gap_err = 0, both_err = 0, stab_err = 0, addr_err = 0;
  logic       prev_accept = 1'b0;
  logic       in_cmd = 1'b0;
  logic [4:0] held_addr = '0;
  logic [31:0] held_data = '0;
  logic [7:0] wr_bytes [$];
  int         reads_q [$];

  // Outputs are stable mid-cycle; the response set here is sampled at the next rising edge.
  always @(negedge avm_clk) begin
    avm_waitrequest = 1'b0;
    avm_readdata    = '0;
    if (!avm_rst_n) begin
      prev_accept = 1'b0;
      in_cmd      = 1'b0;
      stall_seen  = 0;
      zero_seen   = 0;
      reads_since = 0;
    end else begin
      if (avm_read && avm_write) both_err++;
      if (prev_accept && (avm_read || avm_write)) gap_err++;
      prev_accept = 1'b0;
      if (avm_read || avm_write) begin
        if (in_cmd && (avm_address !== held_addr || avm_writedata !== held_data)) stab_err++;
        held_addr = avm_address;
        held_data = avm_writedata;
        in_cmd    = 1'b1;
        if (avm_write && stall_seen < stall_cfg) begin
          avm_waitrequest = 1'b1;
          stall_seen++;
        end else begin
          in_cmd      = 1'b0;
          stall_seen  = 0;
          prev_accept = 1'b1;
          if (avm_read) begin
            if (avm_address !== 5'd8) addr_err++;
            reads_since++;
            if (zero_seen < zero_polls) begin
              zero_seen++;
              avm_readdata = 32'h0000_0000;
            end else begin
              avm_readdata = 32'h0000_0040;
            end
          end else begin
            if (avm_address !== 5'd4) addr_err++;
            wr_bytes.push_back(avm_writedata[7:0]);
            reads_q.push_back(reads_since);
            reads_since = 0;
            zero_seen   = 0;
          end
        end
      end
    end
  end

  task automatic clear_logs();
    wr_bytes.delete();
    reads_q.delete();
    reads_since = 0;
    gap_err = 0; both_err = 0; stab_err = 0; addr_err = 0;
  endtask

  // Returns at the negedge after the accepting edge.
  task automatic push_pixel(input logic [23:0] d, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge avm_clk);
      if (o_ready) begin ok = 1'b1; break; end
    end
    if (ok) begin
      i_data  = d;
      i_valid = 1'b1;
      @(negedge avm_clk);
      i_valid = 1'b0;
    end
  endtask

  task automatic wait_done(input int budget, output int cycles, output bit ok);
    ok = 1'b0;
    cycles = 0;
    while (cycles < budget) begin
      @(negedge avm_clk);
      cycles++;
      if (o_done) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    avm_rst_n = 1'b0;
    repeat (2) @(negedge avm_clk);
    total++; if (avm_read !== 1'b0 || avm_write !== 1'b0) begin bad++;
      $display("FAIL reset_cmd read=%b write=%b want 0 0", avm_read, avm_write); end
    total++; if (avm_address !== 5'd8) begin bad++;
      $display("FAIL reset_addr got=%0d want=8", avm_address); end
    total++; if (avm_writedata !== 32'h0) begin bad++;
      $display("FAIL reset_wdata got=%h want=0", avm_writedata); end
    total++; if (o_done !== 1'b0 || o_pixel_cnt !== 16'd0) begin bad++;
      $display("FAIL reset_done_cnt done=%b cnt=%0d want 0 0", o_done, o_pixel_cnt); end
    total++; if (o_ready !== 1'b1 || o_busy !== 1'b0) begin bad++;
      $display("FAIL reset_ready_busy ready=%b busy=%b want 1 0", o_ready, o_busy); end
    avm_rst_n = 1'b1;
    @(negedge avm_clk);
  endtask

  task automatic check_bytes(input string name, input logic [23:0] pix, input int base);
    logic [7:0] exp [3];
    exp[0] = pix[23:16]; exp[1] = pix[15:8]; exp[2] = pix[7:0];
    for (int b = 0; b < 3; b++) begin
      total++;
      if (wr_bytes.size() <= base + b) begin bad++;
        $display("FAIL %s byte%0d missing (got %0d bytes)", name, base + b, wr_bytes.size());
      end else if (wr_bytes[base + b] !== exp[b]) begin bad++;
        $display("FAIL %s byte%0d got=%h want=%h", name, base + b, wr_bytes[base + b], exp[b]);
      end
    end
  endtask

  task automatic test_single_pixel();
    bit ok; int cyc; int extra;
    clear_logs();
    push_pixel(24'hA1B2C3, ok);
    wait_done(100, cyc, ok);
    total++; if (!ok || cyc !== 12) begin bad++;
      $display("FAIL single_latency ok=%0d cycles=%0d want 12", ok, cyc); end
    extra = 0;
    repeat (15) begin @(negedge avm_clk); if (o_done) extra++; end
    total++; if (extra !== 0) begin bad++;
      $display("FAIL single_done_once extra_pulses=%0d want 0", extra); end
    total++; if (wr_bytes.size() !== 3) begin bad++;
      $display("FAIL single_nbytes got=%0d want=3", wr_bytes.size()); end
    check_bytes("single", 24'hA1B2C3, 0);
    total++; if (o_pixel_cnt !== 16'd1) begin bad++;
      $display("FAIL single_cnt got=%0d want=1", o_pixel_cnt); end
    total++; if (gap_err !== 0 || both_err !== 0 || addr_err !== 0) begin bad++;
      $display("FAIL single_bus gap=%0d both=%0d addr=%0d want 0", gap_err, both_err, addr_err); end
  endtask

  task automatic test_status_poll();
    bit ok; int cyc;
    clear_logs();
    zero_polls = 5;
    push_pixel(24'h0F1E2D, ok);
    wait_done(300, cyc, ok);
    // Each byte: 6 reads + 1 write, each one cycle plus one idle -> 14 cycles.
    total++; if (!ok || cyc !== 42) begin bad++;
      $display("FAIL poll_latency ok=%0d cycles=%0d want 42", ok, cyc); end
    for (int w = 0; w < 3; w++) begin
      total++;
      if (reads_q.size() <= w || reads_q[w] !== 6) begin bad++;
        $display("FAIL poll_reads write%0d got=%0d want=6", w,
                 (reads_q.size() > w) ? reads_q[w] : -1);
      end
    end
    check_bytes("poll", 24'h0F1E2D, 0);
    total++; if (gap_err !== 0 || both_err !== 0) begin bad++;
      $display("FAIL poll_bus gap=%0d both=%0d want 0", gap_err, both_err); end
    total++; if (o_pixel_cnt !== 16'd2) begin bad++;
      $display("FAIL poll_cnt got=%0d want=2", o_pixel_cnt); end
    zero_polls = 0;
  endtask

  task automatic test_write_stall();
    bit ok; int cyc;
    clear_logs();
    stall_cfg = 3;
    push_pixel(24'h5A6B7C, ok);
    wait_done(100, cyc, ok);
    total++; if (!ok || cyc !== 21) begin bad++;
      $display("FAIL stall_latency ok=%0d cycles=%0d want 21", ok, cyc); end
    repeat (3) @(negedge avm_clk);
    total++; if (stab_err !== 0) begin bad++;
      $display("FAIL stall_stable changes=%0d want 0", stab_err); end
    total++; if (wr_bytes.size() !== 3) begin bad++;
      $display("FAIL stall_nbytes got=%0d want=3", wr_bytes.size()); end
    check_bytes("stall", 24'h5A6B7C, 0);
    total++; if (o_pixel_cnt !== 16'd3) begin bad++;
      $display("FAIL stall_cnt got=%0d want=3", o_pixel_cnt); end
    stall_cfg = 0;
  endtask

  task automatic test_back_to_back();
    logic [23:0] pix [6];
    int k, first_low, dones;
    logic busy5, busy6, busy_after;
    pix[0] = 24'h102030; pix[1] = 24'h405060; pix[2] = 24'h708090;
    pix[3] = 24'hA0B0C0; pix[4] = 24'hD0E0F0; pix[5] = 24'h0A0B0C;
    clear_logs();
    k = 0; first_low = -1; dones = 0; busy5 = 1'b0; busy6 = 1'b1;
    for (int cyc = 0; cyc < 400 && dones < 6; cyc++) begin
      @(negedge avm_clk);
      if (o_done) begin
        dones++;
        if (dones == 5) busy5 = o_busy;
        if (dones == 6) busy6 = o_busy;
      end
      if (k < 6 && o_ready) begin
        i_data = pix[k]; i_valid = 1'b1; k++;
      end else begin
        i_valid = 1'b0;
        if (k < 6 && first_low < 0) first_low = cyc;
      end
    end
    i_valid = 1'b0;
    @(negedge avm_clk);
    busy_after = o_busy;
    total++; if (first_low !== 5) begin bad++;
      $display("FAIL b2b_ready_drop cycle=%0d want=5", first_low); end
    total++; if (dones !== 6) begin bad++;
      $display("FAIL b2b_dones got=%0d want=6", dones); end
    total++; if (wr_bytes.size() !== 18) begin bad++;
      $display("FAIL b2b_nbytes got=%0d want=18", wr_bytes.size()); end
    for (int p = 0; p < 6; p++) check_bytes("b2b", pix[p], 3 * p);
    total++; if (busy5 !== 1'b1 || busy6 !== 1'b0 || busy_after !== 1'b0) begin bad++;
      $display("FAIL b2b_busy at5=%b at6=%b after=%b want 1 0 0", busy5, busy6, busy_after); end
    total++; if (o_pixel_cnt !== 16'd9) begin bad++;
      $display("FAIL b2b_cnt got=%0d want=9", o_pixel_cnt); end
  endtask

  task automatic test_reset_mid();
    bit ok; int cyc;
    clear_logs();
    push_pixel(24'h112233, ok);
    ok = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (wr_bytes.size() >= 2) begin ok = 1'b1; break; end
      @(negedge avm_clk);
    end
    total++; if (!ok) begin bad++;
      $display("FAIL rstmid_two_bytes got=%0d want=2", wr_bytes.size()); end
    #2 avm_rst_n = 1'b0;
    #1;
    total++; if (avm_read !== 1'b0 || avm_write !== 1'b0 || avm_address !== 5'd8) begin bad++;
      $display("FAIL rstmid_cmd read=%b write=%b addr=%0d want 0 0 8", avm_read, avm_write, avm_address); end
    total++; if (o_ready !== 1'b1 || o_busy !== 1'b0 || o_pixel_cnt !== 16'd0) begin bad++;
      $display("FAIL rstmid_status ready=%b busy=%b cnt=%0d want 1 0 0", o_ready, o_busy, o_pixel_cnt); end
    @(negedge avm_clk);
    avm_rst_n = 1'b1;
    @(negedge avm_clk);
    clear_logs();
    push_pixel(24'h445566, ok);
    wait_done(100, cyc, ok);
    total++; if (!ok || wr_bytes.size() !== 3) begin bad++;
      $display("FAIL rstmid_resend ok=%0d nbytes=%0d want 3", ok, wr_bytes.size()); end
    check_bytes("rstmid", 24'h445566, 0);
    total++; if (o_pixel_cnt !== 16'd1) begin bad++;
      $display("FAIL rstmid_cnt got=%0d want=1", o_pixel_cnt); end
  endtask

  task automatic test_cnt_wrap();
    logic [1:0] exp [5];
    bit ok;
    exp[0] = 2'd1; exp[1] = 2'd2; exp[2] = 2'd3; exp[3] = 2'd0; exp[4] = 2'd1;
    for (int p = 0; p < 5; p++) begin
      ok = 1'b0;
      for (int c = 0; c < 100; c++) begin
        @(negedge avm_clk);
        if (o_ready2) begin ok = 1'b1; break; end
      end
      i_data2 = 24'h00_0100 * p[23:0]; i_valid2 = ok;
      @(negedge avm_clk);
      i_valid2 = 1'b0;
      ok = 1'b0;
      for (int c = 0; c < 100; c++) begin
        @(negedge avm_clk);
        if (o_done2) begin ok = 1'b1; break; end
      end
      total++; if (!ok || o_pixel_cnt2 !== exp[p]) begin bad++;
        $display("FAIL wrap_cnt pixel%0d ok=%0d got=%0d want=%0d", p, ok, o_pixel_cnt2, exp[p]); end
    end
  endtask

  initial begin
    test_reset();
    test_single_pixel();
    test_status_poll();
    test_write_stall();
    test_back_to_back();
    test_reset_mid();
    test_cnt_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
